// File: rtl/datapath_rtype_pkg.sv
// Shared encodings for the multi-cycle R-type datapath: opcode/funct constants,
// ALU select codes, FSM states and the funct decoder.
package datapath_rtype_pkg;

   localparam logic [5:0] OP_RTYPE   = 6'b000000;

   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;
   localparam logic [5:0] FUNCT_SLL  = 6'b000000;
   localparam logic [5:0] FUNCT_SRL  = 6'b000010;

   localparam logic [3:0] ALU_SEL_ADD = 4'd0;
   localparam logic [3:0] ALU_SEL_SUB = 4'd1;
   localparam logic [3:0] ALU_SEL_AND = 4'd2;
   localparam logic [3:0] ALU_SEL_OR  = 4'd3;
   localparam logic [3:0] ALU_SEL_NOR = 4'd4;
   localparam logic [3:0] ALU_SEL_SLT = 4'd5;
   localparam logic [3:0] ALU_SEL_SLL = 4'd6;
   localparam logic [3:0] ALU_SEL_SRL = 4'd7;

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_e;

   typedef struct packed {
      logic       legal;
      logic [3:0] sel;
   } alu_dec_t;

   function automatic alu_dec_t decode_funct(input logic [5:0] funct);
      alu_dec_t d;
      d.legal = 1'b1;
      d.sel   = ALU_SEL_ADD;
      case (funct)
         FUNCT_ADD: d.sel = ALU_SEL_ADD;
         FUNCT_SUB: d.sel = ALU_SEL_SUB;
         FUNCT_AND: d.sel = ALU_SEL_AND;
         FUNCT_OR:  d.sel = ALU_SEL_OR;
         FUNCT_NOR: d.sel = ALU_SEL_NOR;
         FUNCT_SLT: d.sel = ALU_SEL_SLT;
         FUNCT_SLL: d.sel = ALU_SEL_SLL;
         FUNCT_SRL: d.sel = ALU_SEL_SRL;
         default:   d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/alu_rtype_param.sv
// Combinational R-type ALU, width DATA_W. Shifts act on op2 by shamt and
// yield zero once shamt reaches the datapath width.
module alu_rtype_param
   import datapath_rtype_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] op1,
   input  logic [DATA_W-1:0] op2,
   input  logic [4:0]        shamt,
   input  logic [3:0]        sel,
   output logic [DATA_W-1:0] res,
   output logic              zf
);

   logic w_shamt_big;

   assign w_shamt_big = (32'(shamt) >= DATA_W);

   always_comb begin
      res = '0;
      case (sel)
         ALU_SEL_ADD: res = op1 + op2;
         ALU_SEL_SUB: res = op1 - op2;
         ALU_SEL_AND: res = op1 & op2;
         ALU_SEL_OR:  res = op1 | op2;
         ALU_SEL_NOR: res = ~(op1 | op2);
         ALU_SEL_SLT: res = {{(DATA_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
         ALU_SEL_SLL: res = w_shamt_big ? '0 : (op2 << shamt);
         ALU_SEL_SRL: res = w_shamt_big ? '0 : (op2 >> shamt);
         default:     res = '0;
      endcase
   end

   assign zf = (res == '0);

endmodule

// File: rtl/datapath_rtype_multiciclo.sv
// Multi-cycle R-type datapath: IDLE -> DECODE -> EXEC -> WB, with an inline
// register file (index 0 hardwired to zero) and a combinational debug read port.
module datapath_rtype_multiciclo
   import datapath_rtype_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 32,
   localparam int unsigned REG_AW  = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       instr_in,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic [DATA_W-1:0] result,
   output logic              zf,
   output logic              done,
   output logic              illegal,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   state_e            r_state, w_state_next;
   logic [31:0]       r_ir;
   logic [DATA_W-1:0] r_a, r_b, r_alu_out;
   logic [3:0]        r_sel;
   logic              r_illegal, r_zf;
   logic [DATA_W-1:0] r_regs [NUM_REGS];

   logic [4:0]        w_rs, w_rt, w_rd;
   logic [DATA_W-1:0] w_rs_val, w_rt_val, w_alu_res;
   logic              w_alu_zf, w_wr_en;
   alu_dec_t          w_dec;

   assign w_rs  = r_ir[25:21];
   assign w_rt  = r_ir[20:16];
   assign w_rd  = r_ir[15:11];
   assign w_dec = decode_funct(r_ir[5:0]);

   // Out-of-range and zero indices read as zero.
   always_comb begin
      w_rs_val = '0;
      w_rt_val = '0;
      dbg_data = '0;
      if (w_rs != '0 && 32'(w_rs) < NUM_REGS) w_rs_val = r_regs[w_rs[REG_AW-1:0]];
      if (w_rt != '0 && 32'(w_rt) < NUM_REGS) w_rt_val = r_regs[w_rt[REG_AW-1:0]];
      if (dbg_addr != '0 && 32'(dbg_addr) < NUM_REGS) dbg_data = r_regs[dbg_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      instr_ready  = 1'b0;
      done         = 1'b0;
      unique case (r_state)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) w_state_next = DECODE;
         end
         DECODE: w_state_next = EXEC;
         EXEC:   w_state_next = WB;
         WB: begin
            done         = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign illegal = done & r_illegal;
   assign w_wr_en = done && !r_illegal && (w_rd != '0) && (32'(w_rd) < NUM_REGS);

   alu_rtype_param #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op1   (r_a),
      .op2   (r_b),
      .shamt (r_ir[10:6]),
      .sel   (r_sel),
      .res   (w_alu_res),
      .zf    (w_alu_zf)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ir      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_sel     <= ALU_SEL_ADD;
         r_illegal <= 1'b0;
         r_alu_out <= '0;
         r_zf      <= 1'b1;
         for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
      end else begin
         if (instr_ready && instr_valid) r_ir <= instr_in;
         if (r_state == DECODE) begin
            r_a       <= w_rs_val;
            r_b       <= w_rt_val;
            r_sel     <= w_dec.sel;
            r_illegal <= (r_ir[31:26] != OP_RTYPE) || !w_dec.legal;
         end
         // ALUOut doubles as the visible result, so it only moves on the way into WB.
         if (r_state == EXEC) begin
            r_alu_out <= r_illegal ? '0 : w_alu_res;
            r_zf      <= r_illegal ? 1'b1 : w_alu_zf;
         end
         if (w_wr_en) r_regs[w_rd[REG_AW-1:0]] <= r_alu_out;
      end
   end

   assign result = r_alu_out;
   assign zf     = r_zf;

endmodule
